// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - multi-precision add/subtract sequencer over one shared 8-bit adder slice
module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] a,
  input  logic [8*WORDS-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy
);

  localparam int W  = 8 * WORDS;
  localparam int LW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  // Shared slice signals
  logic [7:0]      lane_a;
  logic [7:0]      lane_b;
  logic [8:0]      lane_res;
  logic [7:0]      low_res;
  logic            carry_into_msb;
  logic            lane_last;

  // Select the active byte lane of each captured operand and run the 9-bit slice
  always_comb begin
    lane_a = 8'd0;
    lane_b = 8'd0;
    for (int i = 0; i < WORDS; i++) begin
      if (lane_q == LW'(i)) begin
        lane_a = opa_q[i*8 +: 8];
        lane_b = opb_q[i*8 +: 8];
      end
    end
    lane_res       = {1'b0, lane_a} + {1'b0, lane_b} + {8'd0, carry_q};
    // Low seven bits alone tell us the carry into bit 7, needed for signed overflow
    low_res        = {1'b0, lane_a[6:0]} + {1'b0, lane_b[6:0]} + {7'd0, carry_q};
    carry_into_msb = low_res[7];
    lane_last      = (lane_q == LW'(WORDS - 1));
  end

  // Next-state and result update; subtraction is folded into an inverted opB and a preloaded carry of 1
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          lane_d  = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (lane_q == LW'(i)) begin
            sum_d[i*8 +: 8] = lane_res[7:0];
          end
        end
        carry_d = lane_res[8];
        if (lane_last) begin
          cout_d  = lane_res[8];
          ovf_d   = carry_into_msb ^ lane_res[8];
          lane_d  = '0;
          state_d = DONE;
        end else begin
          lane_d  = lane_q + LW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        lane_d  = '0;
        carry_d = 1'b0;
        sum_d   = '0;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer. It time-shares one 8-bit adder slice (a+b+cin, carry-out) across WORDS byte lanes, least-significant byte first, chaining the carry between cycles.
- Operands are accepted through a valid/ready handshake. The result is presented through a valid/ready handshake with back-pressure.
- Sits between a register-file/bus front end and the shared 8-bit adder datapath, replacing a full-width combinational adder.

Parameters:
- WORDS, 4, number of 8-bit lanes; operand width is 8*WORDS; legal range 2..16.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request carries valid operands.
- in_ready  output  1  block can accept a request (high only in IDLE).
- a  input  8*WORDS  operand A.
- b  input  8*WORDS  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- sum  output  8*WORDS  result.
- cout  output  1  final carry out of MSB lane; for sub, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB bit XOR carry out of MSB bit.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; lane index=0; carry reg=0.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 (from the first cycle after reset).
  - Reset has priority over every other event, including in RUN or DONE: an in-flight operation is discarded and no out_valid is produced.
- IDLE state:
  - in_ready=1.
  - On an edge with in_valid=1, capture a into opA. Capture b into opB, bitwise inverted if sub=1.
  - Initialise the carry reg: cin if sub=0, 1 if sub=1. Latch sub internally.
  - Set lane index=0, clear the sum register, go to RUN.
  - in_valid=0: stay in IDLE.
  - Captured operands are frozen; changes on a/b/cin/sub after acceptance have no effect.
- RUN state:
  - busy=1, in_ready=0.
  - Each cycle the slice computes the 9-bit result {c,s} = opA[lane] + opB[lane] + carry.
  - On each edge: sum[lane]=s; carry=c; lane increments.
  - On the MSB lane (index WORDS-1):
    - cout=c.
    - ovf = (carry into bit 7 of that lane) XOR c.
    - Go to DONE.
  - in_valid during RUN is ignored; it is not captured or queued.
- Latency: the accept edge is T. out_valid is first high after edge T+WORDS (exactly WORDS cycles), with all of sum, cout and ovf final at that point.
- DONE state:
  - out_valid=1, busy=0, in_ready=0.
  - sum, cout and ovf hold stable until the handshake.
  - On an edge with out_ready=1, go to IDLE; out_valid drops on the next cycle.
  - Result registers keep their values in IDLE until the next accept.
  - No same-cycle re-accept: the minimum issue interval is WORDS+2 cycles.
- Arithmetic:
  - All arithmetic is modulo 2^(8*WORDS).
  - Lane widths are 8 bits; the internal lane adder is 9 bits; the lane index is ceil(log2(WORDS)) bits wide and never exceeds WORDS-1.
- Illegal states: go to IDLE with outputs cleared.
- out_ready while not in DONE: ignored.

Test Plan:
1. Carry ripple (WORDS=4):
   - Stimulus: a=0xFFFFFFFF, b=0, cin=1, sub=0.
   - Response: busy high 4 cycles; out_valid exactly 4 cycles after accept; sum=0x00000000, cout=1, ovf=0.
2. Subtract with borrow:
   - Stimulus: a=5, b=7, sub=1.
   - Response: sum=0xFFFFFFFE, cout=0, ovf=0.
   - Repeat with a=7, b=5: sum=0x00000002, cout=1.
3. Signed overflow:
   - Stimulus: a=0x7FFFFFFF, b=1, cin=0, sub=0.
   - Response: sum=0x80000000, cout=0, ovf=1.
   - Also a=0x80000000, b=1, sub=1: sum=0x7FFFFFFF, ovf=1.
4. Back-pressure and busy-ignore:
   - Stimulus: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands; also pulse in_valid during RUN.
   - Response: sum/cout stable; in_ready=0 throughout; no second capture. After out_ready=1, IDLE is reached and the next request is accepted, giving the correct new result.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 for one edge when lane index=2 of a running add.
   - Response: next cycle state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0. The subsequent request 0x00000001+0x00000001 returns sum=0x00000002.
6. Back-to-back throughput:
   - Stimulus: keep in_valid=1 and out_ready=1 constantly with 3 different operand pairs.
   - Response: three correct results; accepts are spaced WORDS+2=6 cycles apart.
